// File: rtl/lap_tracker.sv
// Lap progress tracker: detects finish-line entries, checkpoint coverage and lap
// timeouts from the per-pixel zone code, and keeps lap count and lap times for the HUD.
module lap_tracker #(
  parameter int unsigned CYCLES_PER_CS  = 650000,
  parameter int unsigned MAX_LAP_CYCLES = 1950000000
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        game_active,
  input  logic [2:0]  zone,
  output logic        lap_finished,
  output logic        checkpoints_passed,
  output logic        max_lap_time_exceeded,
  output logic [3:0]  lap_count,
  output logic [13:0] lap_time_cs,
  output logic [13:0] last_lap_cs,
  output logic [13:0] best_lap_cs
);

  localparam int PRE_W = (CYCLES_PER_CS > 1) ? $clog2(CYCLES_PER_CS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYCLES_PER_CS - 1);
  localparam logic [31:0]      CYC_LAST = 32'(MAX_LAP_CYCLES - 1);
  localparam logic [13:0]      CS_MAX   = 14'd9999;

  typedef enum logic {IDLE, RUNNING} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_cyc;
  logic [PRE_W-1:0] r_pre;
  logic [2:0]       r_mask;
  logic             r_in_fin_prev;
  logic             r_lap_finished;
  logic             r_cp_passed;
  logic             r_timeout;
  logic [3:0]       r_lap_count;
  logic [13:0]      r_lap_time;
  logic [13:0]      r_last_lap;
  logic [13:0]      r_best_lap;

  logic             w_run;
  logic             w_start;
  logic             w_at_fin;
  logic             w_fin_edge;
  logic             w_timeout;
  logic             w_lap_valid;
  logic             w_best_upd;
  logic [2:0]       w_cp_hit;

  function automatic logic [13:0] sat_inc_cs(input logic [13:0] v);
    return (v >= CS_MAX) ? CS_MAX : v + 14'd1;
  endfunction

  function automatic logic [3:0] sat_inc_laps(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (game_active)  w_state_nxt = RUNNING;
      RUNNING: if (!game_active) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A game_active fall overrides everything in the same cycle, so w_run gates all events.
  assign w_run       = (r_state == RUNNING) && game_active;
  assign w_start     = (r_state == IDLE) && game_active;
  assign w_at_fin    = (zone == 3'd1);
  assign w_fin_edge  = w_run && w_at_fin && !r_in_fin_prev;
  assign w_timeout   = w_run && !w_fin_edge && (r_cyc == CYC_LAST);
  assign w_lap_valid = (r_mask == 3'b111);
  assign w_best_upd  = (r_best_lap == 14'd0) || (r_lap_time < r_best_lap);
  assign w_cp_hit    = {zone == 3'd4, zone == 3'd3, zone == 3'd2};

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc          <= '0;
      r_pre          <= '0;
      r_mask         <= '0;
      r_in_fin_prev  <= 1'b1;
      r_lap_finished <= 1'b0;
      r_cp_passed    <= 1'b0;
      r_timeout      <= 1'b0;
      r_lap_count    <= '0;
      r_lap_time     <= '0;
      r_last_lap     <= '0;
      r_best_lap     <= '0;
    end else begin
      r_lap_finished <= w_fin_edge;
      r_timeout      <= w_timeout;

      if (!w_run) begin
        r_cyc         <= '0;
        r_pre         <= '0;
        r_lap_time    <= '0;
        r_mask        <= '0;
        r_in_fin_prev <= 1'b1;
      end else begin
        r_in_fin_prev <= w_at_fin;
        if (w_fin_edge || w_timeout) begin
          r_cyc      <= '0;
          r_pre      <= '0;
          r_lap_time <= '0;
          r_mask     <= '0;
        end else begin
          r_cyc  <= r_cyc + 32'd1;
          r_mask <= r_mask | w_cp_hit;
          if (r_pre == PRE_LAST) begin
            r_pre      <= '0;
            r_lap_time <= sat_inc_cs(r_lap_time);
          end else begin
            r_pre <= r_pre + 1'b1;
          end
        end
      end

      // Display values survive IDLE and are only wiped when a new game starts.
      if (w_start) begin
        r_lap_count <= '0;
        r_last_lap  <= '0;
        r_best_lap  <= '0;
        r_cp_passed <= 1'b0;
      end

      if (w_fin_edge) begin
        r_cp_passed <= w_lap_valid;
        if (w_lap_valid) begin
          r_lap_count <= sat_inc_laps(r_lap_count);
          r_last_lap  <= r_lap_time;
          if (w_best_upd) r_best_lap <= r_lap_time;
        end
      end
    end
  end

  assign lap_finished          = r_lap_finished;
  assign checkpoints_passed    = r_cp_passed;
  assign max_lap_time_exceeded = r_timeout;
  assign lap_count             = r_lap_count;
  assign lap_time_cs           = r_lap_time;
  assign last_lap_cs           = r_last_lap;
  assign best_lap_cs           = r_best_lap;

endmodule
